// File: rtl/lfsr_match_controller.sv
// Search sequencer that steps an external LFSR stage until its output matches a latched key.
// Optional don't-care mask on the compare is enabled with `define MATCH_MASK_EN.
module lfsr_match_controller #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MAX_STEPS = 65535
) (
    input  logic              LFSR_Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Abort,
    input  logic [WIDTH-1:0]  Key,
`ifdef MATCH_MASK_EN
    input  logic [WIDTH-1:0]  Key_Mask,
`endif
    input  logic [3:0]        X_In,
    input  logic [WIDTH-1:0]  LFSR_OUT,
    output logic [3:0]        X,
    output logic              LFSR_Enable,
    output logic              Compare_Found,
    output logic              Busy,
    output logic              Done,
    output logic              Miss,
    output logic [CNT_W-1:0]  Match_Index
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MAX_STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEARCH,
        S_FOUND,
        S_MISS
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  key_r;
    logic [CNT_W-1:0]  step_cnt;
    logic              hit;

`ifdef MATCH_MASK_EN
    logic [WIDTH-1:0]  key_mask_r;

    always_comb hit = (((LFSR_OUT ^ key_r) & ~key_mask_r) == '0);
`else
    always_comb hit = (LFSR_OUT == key_r);
`endif

    // Freeze must reach the LFSR in the hit cycle itself, so it cannot wait for a register.
    always_comb Compare_Found = (state == S_FOUND) || ((state == S_SEARCH) && hit);

    always_ff @(posedge LFSR_Clock) begin
        if (Reset) begin
            state       <= S_IDLE;
            key_r       <= '0;
            step_cnt    <= '0;
            X           <= '0;
            LFSR_Enable <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Miss        <= 1'b0;
            Match_Index <= '0;
`ifdef MATCH_MASK_EN
            key_mask_r  <= '0;
`endif
        end else begin
            Done <= 1'b0;
            if (Abort) begin
                state       <= S_IDLE;
                LFSR_Enable <= 1'b0;
                Busy        <= 1'b0;
                Miss        <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_FOUND, S_MISS: begin
                        if (Start) begin
                            state    <= S_LOAD;
                            key_r    <= Key;
                            X        <= X_In;
                            step_cnt <= '0;
                            Busy     <= 1'b1;
                            Miss     <= 1'b0;
`ifdef MATCH_MASK_EN
                            key_mask_r <= Key_Mask;
`endif
                        end
                    end
                    // One settle cycle so the new X has propagated before the first compare.
                    S_LOAD: begin
                        state       <= S_SEARCH;
                        LFSR_Enable <= 1'b1;
                    end
                    S_SEARCH: begin
                        if (hit) begin
                            state       <= S_FOUND;
                            Match_Index <= step_cnt;
                            Done        <= 1'b1;
                            LFSR_Enable <= 1'b0;
                            Busy        <= 1'b0;
                        end else if (step_cnt == LAST_STEP) begin
                            state       <= S_MISS;
                            Done        <= 1'b1;
                            Miss        <= 1'b1;
                            LFSR_Enable <= 1'b0;
                            Busy        <= 1'b0;
                        end else begin
                            step_cnt <= step_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state       <= S_IDLE;
                        LFSR_Enable <= 1'b0;
                        Busy        <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
